// File: rtl/event_encoder.sv
// Sequential N-to-log2(N) event encoder: captures request rising edges and offers
// one pending index per valid/ready handshake. Optional macro: ROUND_ROBIN_EN.
module event_encoder #(
   parameter int N = 8,
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] in,
   input  logic         clr,
   output logic [W-1:0] out,
   output logic         valid,
   input  logic         ready,
   output logic [N-1:0] pending,
   output logic         overflow
);

   typedef enum logic {S_IDLE, S_OFFER} state_t;

   state_t       r_state;
   logic [N-1:0] r_in_q;
   logic [N-1:0] r_pending;
   logic [W-1:0] r_out;
   logic         r_overflow;

   logic [N-1:0] w_rise;
   logic         w_accept;
   logic [N-1:0] w_grant;
   logic [N-1:0] w_pend_nxt;
   logic [W-1:0] w_base;
   logic [W-1:0] w_idx;
   logic [W-1:0] w_sel;
   logic         w_found;

   assign w_rise     = in & ~r_in_q;
   assign w_accept   = (r_state == S_OFFER) & ready;
   assign w_grant    = w_accept ? (N'(1) << r_out) : '0;
   assign w_pend_nxt = clr ? '0 : ((r_pending & ~w_grant) | w_rise);

`ifdef ROUND_ROBIN_EN
   logic [W-1:0] r_rr_ptr;

   // Search starts just past the index being accepted, so it wraps fairly.
   assign w_base = w_accept ? (r_out + W'(1)) : r_rr_ptr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr <= '0;
      end else if (clr) begin
         r_rr_ptr <= '0;
      end else if (w_accept) begin
         r_rr_ptr <= r_out + W'(1);
      end
   end
`else
   assign w_base = '0;
`endif

   always_comb begin
      w_sel   = '0;
      w_idx   = '0;
      w_found = 1'b0;
      for (int i = 0; i < N; i++) begin
         w_idx = w_base + W'(i);
         if (!w_found && w_pend_nxt[w_idx]) begin
            w_sel   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_in_q     <= '0;
         r_pending  <= '0;
         r_out      <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_in_q     <= in;
         r_pending  <= w_pend_nxt;
         r_overflow <= !clr & |(w_rise & r_pending & ~w_grant);
         if (clr) begin
            r_state <= S_IDLE;
            r_out   <= '0;
         end else begin
            unique case (r_state)
               S_IDLE: begin
                  r_state <= w_found ? S_OFFER : S_IDLE;
                  r_out   <= w_sel;
               end
               S_OFFER: begin
                  if (w_accept) begin
                     r_state <= w_found ? S_OFFER : S_IDLE;
                     r_out   <= w_sel;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_out   <= '0;
               end
            endcase
         end
      end
   end

   assign out      = r_out;
   assign valid    = (r_state == S_OFFER);
   assign pending  = r_pending;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_event_encoder.sv
// Self-checking bench for event_encoder (default fixed-priority build),
// directed scenarios followed by random traffic against a bit-level model.
module tb_event_encoder;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] in_r = '0;
   logic         clr = 1'b0;
   logic         ready = 1'b0;
   logic [W-1:0] out_w;
   logic         valid_w;
   logic [N-1:0] pending_w;
   logic         overflow_w;

   int n_chk = 0;
   int n_fail = 0;

   bit m_prev [N];
   bit m_pend [N];
   bit m_valid;
   bit m_ovf;
   int m_out;

   event_encoder #(.N(N), .W(W)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .in(in_r),
      .clr(clr),
      .out(out_w),
      .valid(valid_w),
      .ready(ready),
      .pending(pending_w),
      .overflow(overflow_w)
   );

   always #5 clk = ~clk;

   function automatic logic [N-1:0] m_pend_vec();
      logic [N-1:0] v;
      v = '0;
      for (int k = 0; k < N; k++) v[k] = m_pend[k];
      return v;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_prev[k] = 1'b0;
         m_pend[k] = 1'b0;
      end
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      m_out   = 0;
   endtask

   // Event-level model: each line is a pending flag; the lowest flagged line is offered.
   task automatic model_step(input logic [N-1:0] i, input logic c, input logic r);
      bit taken;
      bit ovf;
      bit np [N];
      taken = m_valid && r;
      ovf   = 1'b0;
      for (int k = 0; k < N; k++) begin
         bit rose;
         bit keep;
         rose = i[k] && !m_prev[k];
         keep = m_pend[k] && !(taken && m_out == k);
         if (rose && keep) ovf = 1'b1;
         np[k] = c ? 1'b0 : (keep || rose);
         m_prev[k] = i[k];
      end
      for (int k = 0; k < N; k++) m_pend[k] = np[k];
      m_ovf = ovf && !c;
      if (c) begin
         m_valid = 1'b0;
         m_out   = 0;
      end else if (!m_valid || taken) begin
         m_valid = 1'b0;
         m_out   = 0;
         for (int k = N - 1; k >= 0; k--) begin
            if (m_pend[k]) begin
               m_valid = 1'b1;
               m_out   = k;
            end
         end
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, ".out"}, 32'(out_w), 32'(m_out));
      check({tag, ".valid"}, 32'(valid_w), 32'(m_valid));
      check({tag, ".pending"}, 32'(pending_w), 32'(m_pend_vec()));
      check({tag, ".overflow"}, 32'(overflow_w), 32'(m_ovf));
   endtask

   task automatic cycle(input string tag, input logic [N-1:0] i,
                        input logic c, input logic r);
      in_r  = i;
      clr   = c;
      ready = r;
      @(posedge clk);
      model_step(i, c, r);
      #1;
      check_all(tag);
   endtask

   initial begin
      model_reset();
      #12;
      check_all("por");
      @(negedge clk);
      rst_n = 1'b1;
      cycle("idle", 8'h00, 1'b0, 1'b0);

      // Asynchronous reset in the middle of an offer.
      cycle("rst_setup", 8'h05, 1'b0, 1'b0);
      check("rst_setup_pend", 32'(pending_w), 32'h05);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("rst_async");
      @(negedge clk);
      in_r  = 8'h00;
      rst_n = 1'b1;
      cycle("rst_rel", 8'h00, 1'b0, 1'b0);

      // Two simultaneous events drained lowest index first.
      cycle("prio1", 8'h24, 1'b0, 1'b1);
      check("prio1_out", 32'(out_w), 32'd2);
      cycle("prio2", 8'h24, 1'b0, 1'b1);
      check("prio2_out", 32'(out_w), 32'd5);
      cycle("prio3", 8'h24, 1'b0, 1'b1);
      check("prio3_valid", 32'(valid_w), 32'd0);
      cycle("prio4", 8'h00, 1'b0, 1'b0);

      // Stall: higher-priority arrival must not disturb the held offer.
      cycle("stall1", 8'h80, 1'b0, 1'b0);
      cycle("stall2", 8'h82, 1'b0, 1'b0);
      check("stall2_out", 32'(out_w), 32'd7);
      cycle("stall3", 8'h82, 1'b0, 1'b0);
      cycle("stall4", 8'h82, 1'b0, 1'b1);
      check("stall4_out", 32'(out_w), 32'd1);
      cycle("stall5", 8'h00, 1'b0, 1'b1);

      // Collisions on bit 3.
      cycle("coll1", 8'h08, 1'b0, 1'b0);
      cycle("coll2", 8'h00, 1'b0, 1'b0);
      cycle("coll3", 8'h08, 1'b0, 1'b0);
      check("coll3_ovf", 32'(overflow_w), 32'd1);
      cycle("coll4", 8'h08, 1'b0, 1'b0);
      check("coll4_ovf", 32'(overflow_w), 32'd0);
      cycle("coll5", 8'h00, 1'b0, 1'b0);
      cycle("coll6", 8'h08, 1'b0, 1'b1);
      check("coll6_out", 32'(out_w), 32'd3);
      cycle("coll7", 8'h00, 1'b0, 1'b1);

      // Flush with a simultaneous rise, then held-high lines stay quiet.
      cycle("fl1", 8'hFE, 1'b0, 1'b0);
      cycle("fl2", 8'hFF, 1'b0, 1'b0);
      check("fl2_pend", 32'(pending_w), 32'hFF);
      cycle("fl3", 8'hFE, 1'b0, 1'b0);
      cycle("fl4", 8'hFF, 1'b1, 1'b0);
      check("fl4_pend", 32'(pending_w), 32'h00);
      cycle("fl5", 8'hFF, 1'b0, 1'b1);
      cycle("fl6", 8'hFF, 1'b0, 1'b1);
      check("fl6_valid", 32'(valid_w), 32'd0);
      cycle("fl7", 8'h00, 1'b0, 1'b0);

      // Random traffic.
      for (int t = 0; t < 400; t++) begin
         logic [N-1:0] ri;
         logic rc;
         logic rr;
         ri = N'($urandom);
         rc = ($urandom_range(0, 29) == 0);
         rr = ($urandom_range(0, 2) != 0);
         cycle("rand", ri, rc, rr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
